// File: rtl/freq_disp_pkg.sv
// Shared definitions for the frequency display path: formatter FSM states,
// one-hot range codes (LEDR[2:0] mapping) and the display range thresholds.
package freq_disp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_SELECT,
    ST_DONE
  } state_t;

  localparam logic [2:0] RANGE_MHZ = 3'b001;
  localparam logic [2:0] RANGE_KHZ = 3'b010;
  localparam logic [2:0] RANGE_HZ  = 3'b100;

  localparam int THRESH_KHZ = 1000;
  localparam int THRESH_MHZ = 1_000_000;

  // BCD digit index equal to log10 of each threshold.
  localparam int KHZ_DIGIT = 3;
  localparam int MHZ_DIGIT = 6;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble correction cell: a BCD digit of 5 or more gets +3 before the shift.
module bcd_add3 (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  assign dout = (din >= 4'd5) ? din + 4'd3 : din;

endmodule

// File: rtl/freq_bcd_formatter.sv
// Sequential binary-to-BCD converter (one bit per clock) followed by an
// MHz/kHz/Hz range pick that chooses which three digits go to the display.
module freq_bcd_formatter
  import freq_disp_pkg::*;
#(
  parameter int BIN_W  = 27,
  parameter int DIGITS = 9
) (
  input  logic                  MAX10_CLK1_50,
  input  logic                  reset,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_all,
  output logic [3:0]            disp_hi,
  output logic [3:0]            disp_mid,
  output logic [3:0]            disp_lo,
  output logic [2:0]            range_oh
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);

  state_t             state;
  logic [BIN_W-1:0]   bin_sr;
  logic [BCD_W-1:0]   bcd_acc;
  logic [BCD_W-1:0]   bcd_adj;
  logic [CNT_W-1:0]   shift_cnt;

  logic               hi_nz;
  logic               mid_nz;
  logic [2:0]         sel_range;
  logic [3:0]         sel_hi;
  logic [3:0]         sel_mid;
  logic [3:0]         sel_lo;

  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .din  (bcd_acc[4*g +: 4]),
      .dout (bcd_adj[4*g +: 4])
    );
  end

  // Range decision looks only at which BCD digits are nonzero.
  assign hi_nz  = |bcd_acc[BCD_W-1 : 4*MHZ_DIGIT];
  assign mid_nz = |bcd_acc[4*MHZ_DIGIT-1 : 4*KHZ_DIGIT];

  always_comb begin
    sel_range = RANGE_HZ;
    sel_hi    = bcd_acc[11:8];
    sel_mid   = bcd_acc[7:4];
    sel_lo    = bcd_acc[3:0];
    if (hi_nz) begin
      sel_range = RANGE_MHZ;
      sel_hi    = bcd_acc[4*(MHZ_DIGIT+2) +: 4];
      sel_mid   = bcd_acc[4*(MHZ_DIGIT+1) +: 4];
      sel_lo    = bcd_acc[4*MHZ_DIGIT     +: 4];
    end else if (mid_nz) begin
      sel_range = RANGE_KHZ;
      sel_hi    = bcd_acc[4*(KHZ_DIGIT+2) +: 4];
      sel_mid   = bcd_acc[4*(KHZ_DIGIT+1) +: 4];
      sel_lo    = bcd_acc[4*KHZ_DIGIT     +: 4];
    end
  end

  always_ff @(posedge MAX10_CLK1_50) begin
    if (reset) begin
      state     <= ST_IDLE;
      bin_sr    <= '0;
      bcd_acc   <= '0;
      shift_cnt <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      bcd_all   <= '0;
      disp_hi   <= '0;
      disp_mid  <= '0;
      disp_lo   <= '0;
      range_oh  <= 3'b000;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            bin_sr    <= bin_in;
            bcd_acc   <= '0;
            shift_cnt <= '0;
            busy      <= 1'b1;
            state     <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          {bcd_acc, bin_sr} <= {bcd_adj, bin_sr} << 1;
          shift_cnt         <= shift_cnt + 1'b1;
          if (shift_cnt == CNT_W'(BIN_W - 1)) begin
            state <= ST_SELECT;
          end
        end
        ST_SELECT: begin
          bcd_all  <= bcd_acc;
          disp_hi  <= sel_hi;
          disp_mid <= sel_mid;
          disp_lo  <= sel_lo;
          range_oh <= sel_range;
          busy     <= 1'b0;
          done     <= 1'b1;
          state    <= ST_DONE;
        end
        ST_DONE: begin
          // A start seen here is dropped; the source re-asserts it.
          done  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_freq_bcd_formatter.sv
// Bench for freq_bcd_formatter: directed conversions, held start, reset abort.
module tb_freq_bcd_formatter;

  localparam int BIN_W = 27;
  localparam int DIGITS = 9;
  localparam int W = 4*DIGITS + 12 + 3;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 start = 1'b0;
  logic [BIN_W-1:0]     bin_in = '0;
  logic                 busy;
  logic                 done;
  logic [4*DIGITS-1:0]  bcd_all;
  logic [3:0]           disp_hi;
  logic [3:0]           disp_mid;
  logic [3:0]           disp_lo;
  logic [2:0]           range_oh;

  freq_bcd_formatter #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
    .MAX10_CLK1_50 (clk),
    .reset         (reset),
    .start         (start),
    .bin_in        (bin_in),
    .busy          (busy),
    .done          (done),
    .bcd_all       (bcd_all),
    .disp_hi       (disp_hi),
    .disp_mid      (disp_mid),
    .disp_lo       (disp_lo),
    .range_oh      (range_oh)
  );

  // clock / reset
  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail = 0;

  logic [W-1:0] exp_q[$];
  int           exp_cyc_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin : monitor
    logic [W-1:0] e;
    int           ec;
    if (!reset && done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", done, 0);
      end else begin
        e  = exp_q.pop_front();
        ec = exp_cyc_q.pop_front();
        check("done_latency", cyc, ec);
        check("bcd_all", bcd_all, e[W-1:15]);
        check("disp_hi", disp_hi, e[14:11]);
        check("disp_mid", disp_mid, e[10:7]);
        check("disp_lo", disp_lo, e[6:3]);
        check("range_oh", range_oh, e[2:0]);
        check("busy_at_done", busy, 0);
      end
    end
  end

  // driver
  task automatic convert(input logic [BIN_W-1:0] v, input logic [4*DIGITS-1:0] b,
                         input logic [3:0] h, input logic [3:0] m, input logic [3:0] l,
                         input logic [2:0] r);
    @(negedge clk);
    start  = 1'b1;
    bin_in = v;
    exp_q.push_back({b, h, m, l, r});
    exp_cyc_q.push_back(cyc + 29);
    @(negedge clk);
    start  = 1'b0;
    bin_in = BIN_W'($urandom);
    check("busy_after_start", busy, 1);
    repeat (30) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_bcd_all"}, bcd_all, 0);
    check({tag, "_disp_hi"}, disp_hi, 0);
    check({tag, "_disp_mid"}, disp_mid, 0);
    check({tag, "_disp_lo"}, disp_lo, 0);
    check({tag, "_range_oh"}, range_oh, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0;

    convert(27'd0,         36'h000000000, 4'd0, 4'd0, 4'd0, 3'b100);
    convert(27'd999,       36'h000000999, 4'd9, 4'd9, 4'd9, 3'b100);
    convert(27'd1000,      36'h000001000, 4'd0, 4'd0, 4'd1, 3'b010);
    convert(27'd999999,    36'h000999999, 4'd9, 4'd9, 4'd9, 3'b010);
    convert(27'd12345,     36'h000012345, 4'd0, 4'd1, 4'd2, 3'b010);
    convert(27'd1000000,   36'h001000000, 4'd0, 4'd0, 4'd1, 3'b001);
    convert(27'd50000000,  36'h050000000, 4'd0, 4'd5, 4'd0, 3'b001);
    convert(27'd134217727, 36'h134217727, 4'd1, 4'd3, 4'd4, 3'b001);

    // start held high for 40 cycles: only 100 (first) and 130 (first start after DONE) convert
    @(negedge clk);
    for (int i = 0; i < 40; i++) begin
      start  = 1'b1;
      bin_in = BIN_W'(100 + i);
      if (i == 0) begin
        exp_q.push_back({36'h000000100, 4'd1, 4'd0, 4'd0, 3'b100});
        exp_cyc_q.push_back(cyc + 29);
      end
      if (i == 30) begin
        exp_q.push_back({36'h000000130, 4'd1, 4'd3, 4'd0, 3'b100});
        exp_cyc_q.push_back(cyc + 29);
      end
      @(negedge clk);
    end
    start = 1'b0;
    repeat (30) @(negedge clk);

    // reset in the middle of shifting, together with a start: reset wins
    start  = 1'b1;
    bin_in = 27'd1234;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    check("busy_mid_shift", busy, 1);
    reset = 1'b1;
    start = 1'b1;
    @(negedge clk);
    check_reset_outputs("abort");
    reset = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check("busy_after_abort", busy, 0);
    repeat (35) @(negedge clk);

    convert(27'd1234, 36'h000001234, 4'd0, 4'd0, 4'd1, 3'b010);

    repeat (5) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
